// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: memory-mapped interconnect between the FemtoRV32 memory
// port and up to N_SLAVES peripherals.
//
// A request seen in IDLE is decoded against a table of 64 KiB windows
// (mem_addr[31:16]), the chosen slave is latched for the whole transaction
// and gets a single-cycle s_rd/s_wr strobe. Slave busy is merged back to the
// CPU, read data is registered, and a watchdog aborts slaves that stall for
// TIMEOUT_CYCLES wait cycles. Unmapped and timed-out accesses set sticky
// flags plus an error address, readable through the fabric status block.
//
// Ports:
//   clk, resetn         system clock, synchronous active-low reset
//   mem_addr            CPU address
//   mem_rstrb           CPU read strobe
//   mem_wdata           CPU write data
//   mem_wmask           CPU byte write mask (any bit set = write)
//   mem_rdata           registered read data
//   mem_rbusy/wbusy     read/write stall to the CPU
//   s_rd/s_wr           per-slave one-cycle read/write strobes
//   s_wdata             write data to all slaves (mem_wdata unchanged)
//   s_rdata             slave i read data at [32i+:32]
//   s_rbusy/s_wbusy     per-slave read/write busy
module femto_bus_fabric #(
    parameter int unsigned                N_SLAVES       = 4,
    parameter logic [N_SLAVES*16-1:0]     SLAVE_BASE     = {16'h0043, 16'h0042, 16'h0040, 16'h0000},
    parameter bit                         DEFAULT_EN     = 1'b1,
    parameter int unsigned                DEFAULT_SLAVE  = 0,
    parameter logic [15:0]                STATUS_BASE    = 16'h00FF,
    parameter int unsigned                TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]                ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_rstrb,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wmask,
    output logic [31:0]           mem_rdata,
    output logic                  mem_rbusy,
    output logic                  mem_wbusy,
    output logic [N_SLAVES-1:0]   s_rd,
    output logic [N_SLAVES-1:0]   s_wr,
    output logic [31:0]           s_wdata,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]   s_rbusy,
    input  logic [N_SLAVES-1:0]   s_wbusy
);

    localparam int unsigned IdxW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StErrResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       addr_q, addr_d;
    logic              is_rd_q, is_rd_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              unmapped_q, unmapped_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              wr_req, rd_req;
    logic              sel_status, hit;
    logic [IdxW-1:0]   hit_idx;
    logic [31:0]       status_word;
    logic              wd_expire;

    assign s_wdata   = mem_wdata;
    assign mem_rdata = rdata_q;

    // A write wins over a simultaneous read strobe; that read is dropped.
    assign wr_req = |mem_wmask;
    assign rd_req = mem_rstrb & ~wr_req;

    // Address decode: status block first, then lowest matching slot, then default.
    always_comb begin
        sel_status = (mem_addr[31:16] == STATUS_BASE);
        hit        = 1'b0;
        hit_idx    = '0;
        // Walk downwards so the lowest matching index is the last assignment.
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (mem_addr[31:16] == SLAVE_BASE[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
        if (!hit && DEFAULT_EN) begin
            hit     = 1'b1;
            hit_idx = IdxW'(DEFAULT_SLAVE);
        end
    end

    // Status block, word addressed within its window.
    always_comb begin
        case (mem_addr[15:2])
            14'd0:   status_word = {30'b0, timeout_q, unmapped_q};
            14'd1:   status_word = err_addr_q;
            default: status_word = '0;
        endcase
    end

    // Fires on the wait cycle that brings the counter up to TIMEOUT_CYCLES.
    assign wd_expire = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        is_rd_d    = is_rd_q;
        rdata_d    = rdata_q;
        unmapped_d = unmapped_q;
        timeout_d  = timeout_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        s_rd       = '0;
        s_wr       = '0;
        mem_rbusy  = 1'b0;
        mem_wbusy  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (wr_req || rd_req) begin
                    addr_d    = mem_addr;
                    is_rd_d   = rd_req;
                    mem_rbusy = rd_req;
                    mem_wbusy = wr_req;
                    if (sel_status) begin
                        state_d = StErrResp;
                        if (rd_req) begin
                            rdata_d = status_word;
                        end else begin
                            unmapped_d = 1'b0;
                            timeout_d  = 1'b0;
                        end
                    end else if (hit) begin
                        idx_d = hit_idx;
                        if (rd_req) begin
                            s_rd[hit_idx] = 1'b1;
                            state_d       = StRdWait;
                        end else begin
                            s_wr[hit_idx] = 1'b1;
                            state_d       = StWrWait;
                        end
                    end else begin
                        unmapped_d = 1'b1;
                        err_addr_d = mem_addr;
                        if (rd_req) begin
                            rdata_d = ERR_DATA;
                        end
                        state_d = StErrResp;
                    end
                end
            end

            StRdWait: begin
                mem_rbusy = 1'b1;
                if (!s_rbusy[idx_q]) begin
                    rdata_d = s_rdata[32*int'(idx_q) +: 32];
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (wd_expire) begin
                        timeout_d  = 1'b1;
                        err_addr_d = addr_q;
                        rdata_d    = ERR_DATA;
                        state_d    = StIdle;
                    end
                end
            end

            StWrWait: begin
                mem_wbusy = 1'b1;
                if (!s_wbusy[idx_q]) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (wd_expire) begin
                        timeout_d  = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = StIdle;
                    end
                end
            end

            StErrResp: begin
                mem_rbusy = is_rd_q;
                mem_wbusy = ~is_rd_q;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // No strobes or stalls while reset is held.
        if (!resetn) begin
            s_rd      = '0;
            s_wr      = '0;
            mem_rbusy = 1'b0;
            mem_wbusy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            rdata_q    <= '0;
            unmapped_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            is_rd_q    <= is_rd_d;
            rdata_q    <= rdata_d;
            unmapped_q <= unmapped_d;
            timeout_q  <= timeout_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Randomized bench for femto_bus_fabric against a transaction-level model.
module tb_femto_bus_fabric;

    localparam int unsigned NS      = 4;
    // Slots 0 and 1 overlap on purpose; slot 1 must never be selected.
    localparam logic [63:0] BASES   = {16'h0043, 16'h0042, 16'h0040, 16'h0040};
    localparam int unsigned TO      = 8;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;
    localparam int          FOREVER = 99;

    logic            clk = 1'b0;
    logic            resetn;
    logic [31:0]     mem_addr;
    logic            mem_rstrb;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wmask;
    logic [31:0]     mem_rdata;
    logic            mem_rbusy;
    logic            mem_wbusy;
    logic [NS-1:0]   s_rd;
    logic [NS-1:0]   s_wr;
    logic [31:0]     s_wdata;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]   s_rbusy;
    logic [NS-1:0]   s_wbusy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic        m_unm      = 1'b0;
    logic        m_to       = 1'b0;
    logic [31:0] m_err_addr = '0;
    logic [31:0] m_rdata    = '0;
    logic [63:0] bases      = BASES;

    always #5 clk = ~clk;

    femto_bus_fabric #(
        .N_SLAVES       (NS),
        .SLAVE_BASE     (BASES),
        .DEFAULT_EN     (1'b0),
        .DEFAULT_SLAVE  (0),
        .STATUS_BASE    (16'h00FF),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .s_rd      (s_rd),
        .s_wr      (s_wr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_rbusy   (s_rbusy),
        .s_wbusy   (s_wbusy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // -2 = status block, -1 = unmapped, else slave index (lowest match).
    function automatic int decode(input logic [31:0] a);
        if (a[31:16] == 16'h00FF) return -2;
        for (int i = 0; i < int'(NS); i++) begin
            if (a[31:16] == bases[16*i +: 16]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] status_of(input logic [31:0] a);
        if (a[15:2] == 14'd0) return {30'b0, m_to, m_unm};
        if (a[15:2] == 14'd1) return m_err_addr;
        return 32'h0;
    endfunction

    // One CPU access. lat = number of wait cycles the target slave stays busy
    // (FOREVER forces a watchdog abort). Junk requests are driven while the
    // fabric should be busy; they must be ignored.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic rstrb,
                          input logic [3:0] wmask, input int lat);
        int            tgt;
        bit            is_wr, is_rd;
        int            exp_busy;
        logic [NS-1:0] exp_rd, exp_wr, rd_seen, wr_seen;
        int            rb_cnt, wb_cnt, rd_pulses, wr_pulses;
        is_wr = |wmask;
        is_rd = rstrb && !is_wr;
        tgt   = decode(addr);
        for (int i = 0; i < int'(NS); i++) s_rdata[32*i +: 32] = $urandom();
        exp_rd = '0;
        exp_wr = '0;
        if (tgt >= 0) begin
            if (is_rd) exp_rd[tgt] = 1'b1;
            else       exp_wr[tgt] = 1'b1;
            if (lat >= int'(TO)) begin
                exp_busy   = 1 + int'(TO);
                m_to       = 1'b1;
                m_err_addr = addr;
                if (is_rd) m_rdata = ERR;
            end else begin
                exp_busy = lat + 2;
                if (is_rd) m_rdata = s_rdata[32*tgt +: 32];
            end
        end else if (tgt == -1) begin
            exp_busy   = 2;
            m_unm      = 1'b1;
            m_err_addr = addr;
            if (is_rd) m_rdata = ERR;
        end else begin
            exp_busy = 2;
            if (is_rd) m_rdata = status_of(addr);
            else begin
                m_unm = 1'b0;
                m_to  = 1'b0;
            end
        end

        rb_cnt = 0; wb_cnt = 0; rd_pulses = 0; wr_pulses = 0;
        rd_seen = '0; wr_seen = '0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                mem_addr  = addr;
                mem_rstrb = rstrb;
                mem_wmask = wmask;
                mem_wdata = $urandom();
            end else if (c < exp_busy) begin
                mem_addr  = $urandom();
                mem_rstrb = 1'($urandom());
                mem_wmask = 4'($urandom());
            end else begin
                mem_rstrb = 1'b0;
                mem_wmask = 4'b0;
            end
            s_rbusy = NS'($urandom());
            s_wbusy = NS'($urandom());
            if (tgt >= 0) begin
                s_rbusy[tgt] = (c <= lat);
                s_wbusy[tgt] = (c <= lat);
            end
            @(negedge clk);
            rb_cnt    += int'(mem_rbusy);
            wb_cnt    += int'(mem_wbusy);
            rd_pulses += $countones(s_rd);
            wr_pulses += $countones(s_wr);
            rd_seen   |= s_rd;
            wr_seen   |= s_wr;
            if (c >= exp_busy && !mem_rbusy && !mem_wbusy) break;
        end
        check_eq({tag, "/rbusy_cycles"}, 32'(rb_cnt), is_rd ? 32'(exp_busy) : 32'd0);
        check_eq({tag, "/wbusy_cycles"}, 32'(wb_cnt), is_wr ? 32'(exp_busy) : 32'd0);
        check_eq({tag, "/s_rd_mask"}, 32'(rd_seen), 32'(exp_rd));
        check_eq({tag, "/s_wr_mask"}, 32'(wr_seen), 32'(exp_wr));
        check_eq({tag, "/s_rd_pulses"}, 32'(rd_pulses), 32'($countones(exp_rd)));
        check_eq({tag, "/s_wr_pulses"}, 32'(wr_pulses), 32'($countones(exp_wr)));
        check_eq({tag, "/rdata"}, mem_rdata, m_rdata);
    endtask

    initial begin
        logic [15:0] uppers [5];
        logic [31:0] a;
        logic        rs;
        logic [3:0]  wm;
        int          lat;
        int          k;
        uppers = '{16'h0040, 16'h0042, 16'h0043, 16'h00FF, 16'h1234};

        resetn    = 1'b0;
        mem_addr  = '0;
        mem_rstrb = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        s_rdata   = '0;
        s_rbusy   = '0;
        s_wbusy   = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_eq("reset/rdata", mem_rdata, 32'h0);
        check_eq("reset/rbusy", 32'(mem_rbusy), 32'h0);
        check_eq("reset/wbusy", 32'(mem_wbusy), 32'h0);
        check_eq("reset/s_rd", 32'(s_rd), 32'h0);
        check_eq("reset/s_wr", 32'(s_wr), 32'h0);

        // Directed cases.
        do_txn("rd_overlap", 32'h0040_0004, 1'b1, 4'b0000, 3);
        do_txn("wr_slot2", 32'h0042_0000, 1'b0, 4'b0001, 0);
        do_txn("rd_unmapped", 32'h0050_0000, 1'b1, 4'b0000, 0);
        do_txn("st_flags1", 32'h00FF_0000, 1'b1, 4'b0000, 0);
        do_txn("st_erraddr1", 32'h00FF_0004, 1'b1, 4'b0000, 0);
        do_txn("st_other", 32'h00FF_0008, 1'b1, 4'b0000, 0);
        do_txn("rd_timeout", 32'h0043_0010, 1'b1, 4'b0000, FOREVER);
        do_txn("st_flags2", 32'h00FF_0000, 1'b1, 4'b0000, 0);
        do_txn("st_erraddr2", 32'h00FF_0004, 1'b1, 4'b0000, 0);
        do_txn("st_clear", 32'h00FF_0000, 1'b0, 4'b1111, 0);
        do_txn("st_flags3", 32'h00FF_0000, 1'b1, 4'b0000, 0);
        do_txn("rd_and_wr", 32'h0043_0000, 1'b1, 4'b0100, 2);
        do_txn("wr_timeout", 32'h0042_0020, 1'b0, 4'b0011, FOREVER);
        do_txn("st_flags4", 32'h00FF_0000, 1'b1, 4'b0000, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 4);
            a = {uppers[k], 16'($urandom())};
            if (k == 3) a[15:0] = 16'($urandom_range(0, 3) << 2);
            case ($urandom_range(0, 2))
                0:       begin rs = 1'b1; wm = 4'b0000; end
                1:       begin rs = 1'($urandom()); wm = 4'($urandom_range(1, 15)); end
                default: begin rs = 1'b1; wm = 4'($urandom_range(1, 15)); end
            endcase
            lat = $urandom_range(0, 7);
            if (lat > 5) lat = FOREVER;
            do_txn("rand", a, rs, wm, lat);
        end

        // Reset in the middle of a stalled read, with flags set beforehand.
        do_txn("pre_rst_unmapped", 32'h0777_0000, 1'b1, 4'b0000, 0);
        @(posedge clk);
        #1;
        mem_addr  = 32'h0043_0000;
        mem_rstrb = 1'b1;
        s_rbusy   = '1;
        @(posedge clk);
        #1;
        mem_rstrb = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_eq("midrst/rdata", mem_rdata, 32'h0);
        check_eq("midrst/rbusy", 32'(mem_rbusy), 32'h0);
        check_eq("midrst/wbusy", 32'(mem_wbusy), 32'h0);
        check_eq("midrst/s_rd", 32'(s_rd), 32'h0);
        m_unm      = 1'b0;
        m_to       = 1'b0;
        m_err_addr = '0;
        m_rdata    = '0;
        do_txn("post_rst_rd", 32'h0042_0008, 1'b1, 4'b0000, 1);
        do_txn("post_rst_flags", 32'h00FF_0000, 1'b1, 4'b0000, 0);
        do_txn("post_rst_erraddr", 32'h00FF_0004, 1'b1, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
